// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared types, constants and helpers for the lfsr_gen block and its step
// sub-module.
//   lfsr_mode_e : run-time structure select (Fibonacci / Galois)
//   TAPS_Wn     : maximal-length feedback masks for common widths
//   gmask()     : derives the Galois xor mask from a Fibonacci-style tap mask
// -----------------------------------------------------------------------------
package lfsr_pkg;

  typedef enum logic {
    LFSR_FIB = 1'b0,
    LFSR_GAL = 1'b1
  } lfsr_mode_e;

  localparam int unsigned LFSR_WIDTH_MIN = 3;
  localparam int unsigned LFSR_WIDTH_MAX = 32;
  localparam int unsigned LFSR_STEPS_MAX = 8;

  // Default maximal-length tap masks (bit i set => term x^(i+1)).
  localparam logic [5:0]  TAPS_W6  = 6'h30;
  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [15:0] TAPS_W16 = 16'hB400;
  localparam logic [31:0] TAPS_W32 = 32'h8020_0003;

  // Galois mask for a left-shifting register: the x^W term falls off the top,
  // the remaining taps move up one position and the constant term enters at
  // bit 0. Bits at or above 'width' are cleared so the result can be
  // truncated safely to the register width.
  function automatic logic [31:0] gmask(input logic [31:0] taps,
                                        input int unsigned width);
    logic [31:0] keep;
    keep = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return ((taps << 1) | 32'd1) & keep;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// -----------------------------------------------------------------------------
// lfsr_step
// Purely combinational single LFSR advance, selectable between Fibonacci and
// Galois structure. lfsr_gen chains several of these to take multiple steps
// per clock.
//
// Parameters
//   WIDTH : state width in bits
//   TAPS  : feedback mask, bit i set => term x^(i+1); bit WIDTH-1 must be set
// Ports
//   state (in)  : current state
//   mode  (in)  : LFSR_FIB or LFSR_GAL
//   next  (out) : state after exactly one step
// -----------------------------------------------------------------------------
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(16'hB400)
) (
  input  logic [WIDTH-1:0] state,
  input  lfsr_mode_e       mode,
  output logic [WIDTH-1:0] next
);

  localparam logic [WIDTH-1:0] GMASK = WIDTH'(gmask(32'(TAPS), WIDTH));

  logic [WIDTH-1:0] fib_next;
  logic [WIDTH-1:0] gal_next;

  // Fibonacci: parity of the tapped bits is shifted in at the bottom.
  assign fib_next = {state[WIDTH-2:0], ^(state & TAPS)};

  // Galois: the bit shifted out of the top is folded back through the mask.
  assign gal_next = {state[WIDTH-2:0], 1'b0} ^ ({WIDTH{state[WIDTH-1]}} & GMASK);

  always_comb begin
    next = fib_next;
    unique case (mode)
      LFSR_FIB: next = fib_next;
      LFSR_GAL: next = gal_next;
      default:  next = fib_next;
    endcase
  end

endmodule

// File: rtl/lfsr_gen.sv
// -----------------------------------------------------------------------------
// lfsr_gen
// Parametrised LFSR pattern generator with run-time Fibonacci/Galois select,
// synchronous seed load, all-zero lockup protection, and sequence-wrap
// detection with period measurement.
//
// Parameters
//   WIDTH        : state width, 3..32
//   TAPS         : feedback mask, bit i set => term x^(i+1); bit WIDTH-1 set
//   STEPS        : LFSR advances per enabled clock, 1..8 (unrolled chain)
//   DEFAULT_SEED : reset / recovery seed, non-zero
// Ports
//   clk        (in)  : clock
//   rst_n      (in)  : asynchronous active-low reset
//   enable     (in)  : advance by STEPS this cycle
//   mode       (in)  : 0 = Fibonacci, 1 = Galois, sampled every cycle
//   load       (in)  : load seed_in this cycle, wins over enable
//   seed_in    (in)  : seed for load (zero is replaced by DEFAULT_SEED)
//   lfsr_out   (out) : current state
//   wrap       (out) : 1-cycle pulse when the sequence revisits the seed
//   lockup     (out) : 1-cycle pulse when an all-zero state/seed was replaced
//   period_out (out) : enabled cycles to the first wrap after load/reset
//   period_vld (out) : period_out holds a valid measurement
// -----------------------------------------------------------------------------
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH        = 16,
  parameter logic [WIDTH-1:0] TAPS         = WIDTH'(16'hB400),
  parameter int unsigned      STEPS        = 1,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] lfsr_out,
  output logic             wrap,
  output logic             lockup,
  output logic [WIDTH-1:0] period_out,
  output logic             period_vld
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] state_q,      state_d;
  logic [WIDTH-1:0] seed_ref_q,   seed_ref_d;
  logic [WIDTH-1:0] step_cnt_q,   step_cnt_d;
  logic [WIDTH-1:0] period_q,     period_d;
  logic             period_vld_q, period_vld_d;
  logic             wrap_q,       wrap_d;
  logic             lockup_q,     lockup_d;

  lfsr_mode_e       mode_e;
  logic [WIDTH-1:0] chain_out;
  logic [STEPS-1:0] seed_hit;
  logic [WIDTH-1:0] cnt_inc;

  assign mode_e = lfsr_mode_e'(mode);

  // ---------------------------------------------------------------------------
  // Unrolled step chain. Every intermediate state is compared against the
  // reference seed so a wrap landing in the middle of a multi-step advance is
  // still reported.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < STEPS; gi++) begin : g_step
    logic [WIDTH-1:0] stage_in;
    logic [WIDTH-1:0] stage_out;

    if (gi == 0) begin : g_first
      assign stage_in = state_q;
    end else begin : g_rest
      assign stage_in = g_step[gi-1].stage_out;
    end

    lfsr_step #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS)
    ) u_step (
      .state (stage_in),
      .mode  (mode_e),
      .next  (stage_out)
    );

    assign seed_hit[gi] = (stage_out == seed_ref_q);
  end

  assign chain_out = g_step[STEPS-1].stage_out;

  // Saturating cycle count; also the period value when the first wrap lands.
  assign cnt_inc = (step_cnt_q == '1) ? step_cnt_q : (step_cnt_q + ONE);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    seed_ref_d   = seed_ref_q;
    step_cnt_d   = step_cnt_q;
    period_d     = period_q;
    period_vld_d = period_vld_q;
    wrap_d       = 1'b0;
    lockup_d     = 1'b0;

    if (load) begin
      step_cnt_d   = '0;
      period_vld_d = 1'b0;
      if (seed_in != '0) begin
        state_d    = seed_in;
        seed_ref_d = seed_in;
      end else begin
        // An all-zero seed would lock the register; substitute the default.
        state_d    = DEFAULT_SEED;
        seed_ref_d = DEFAULT_SEED;
        lockup_d   = 1'b1;
      end
    end else if (state_q == '0) begin
      // Should never happen with a valid seed; recover instead of sticking.
      state_d  = DEFAULT_SEED;
      lockup_d = 1'b1;
    end else if (enable) begin
      state_d    = chain_out;
      step_cnt_d = cnt_inc;
      if (|seed_hit) begin
        wrap_d = 1'b1;
        // Only the first return after load/reset defines the period.
        if (!period_vld_q) begin
          period_d     = cnt_inc;
          period_vld_d = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= DEFAULT_SEED;
      seed_ref_q   <= DEFAULT_SEED;
      step_cnt_q   <= '0;
      period_q     <= '0;
      period_vld_q <= 1'b0;
      wrap_q       <= 1'b0;
      lockup_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      seed_ref_q   <= seed_ref_d;
      step_cnt_q   <= step_cnt_d;
      period_q     <= period_d;
      period_vld_q <= period_vld_d;
      wrap_q       <= wrap_d;
      lockup_q     <= lockup_d;
    end
  end

  assign lfsr_out   = state_q;
  assign wrap       = wrap_q;
  assign lockup     = lockup_q;
  assign period_out = period_q;
  assign period_vld = period_vld_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// -----------------------------------------------------------------------------
// tb_lfsr_gen
// Two 6-bit generators (x^6+x^5+1, seed 01) driven by the same stimulus: one
// taking one step per enable, one taking three. A polynomial-level model
// predicts every output each cycle; directed literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_lfsr_gen;

  localparam int MASK = 63;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       mode = 1'b0;
  logic       load = 1'b0;
  logic [5:0] seed_in = 6'h00;

  logic [5:0] out1, per1, out3, per3;
  logic       wrap1, lock1, vld1, wrap3, lock3, vld3;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_on   = 1'b0;
  bit verbose  = 1'b1;

  always #5 clk = ~clk;

  lfsr_gen #(.WIDTH(6), .TAPS(6'h30), .STEPS(1), .DEFAULT_SEED(6'h01)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .load(load),
    .seed_in(seed_in), .lfsr_out(out1), .wrap(wrap1), .lockup(lock1),
    .period_out(per1), .period_vld(vld1));

  lfsr_gen #(.WIDTH(6), .TAPS(6'h30), .STEPS(3), .DEFAULT_SEED(6'h01)) dut3 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .load(load),
    .seed_in(seed_in), .lfsr_out(out3), .wrap(wrap3), .lockup(lock3),
    .period_out(per3), .period_vld(vld3));

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    int state;
    int ref_s;
    int cnt;
    int per;
    bit vld;
    bit wrap;
    bit lock;
  } mdl_t;

  mdl_t m1, m3;

  // Fibonacci: new bottom bit is the parity of the tapped bits x^5, x^6.
  function automatic int fib1(int s);
    return ((s * 2) & MASK) | ($countones(s & 'h30) & 1);
  endfunction

  // Galois: multiply by x modulo x^6+x^5+1, i.e. x^6 reduces to x^5+1.
  function automatic int gal1(int s);
    int t;
    t = (s * 2) & MASK;
    if (s >= 32) t = t ^ 'h21;
    return t;
  endfunction

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.state = 1; r.ref_s = 1; r.cnt = 0; r.per = 0;
    r.vld = 1'b0; r.wrap = 1'b0; r.lock = 1'b0;
    return r;
  endfunction

  function automatic mdl_t mdl_next(mdl_t c, int steps, bit ld, bit en,
                                    bit md, int seed);
    mdl_t n;
    int   s;
    bit   hit;
    n = c;
    n.wrap = 1'b0;
    n.lock = 1'b0;
    if (ld) begin
      n.cnt = 0;
      n.vld = 1'b0;
      if (seed != 0) begin
        n.state = seed; n.ref_s = seed;
      end else begin
        n.state = 1; n.ref_s = 1; n.lock = 1'b1;
      end
    end else if (c.state == 0) begin
      n.state = 1;
      n.lock  = 1'b1;
    end else if (en) begin
      s   = c.state;
      hit = 1'b0;
      for (int i = 0; i < steps; i++) begin
        s = md ? gal1(s) : fib1(s);
        if (s == c.ref_s) hit = 1'b1;
      end
      n.state = s;
      n.cnt   = (c.cnt + 1 > MASK) ? MASK : c.cnt + 1;
      if (hit) begin
        n.wrap = 1'b1;
        if (!c.vld) begin
          n.per = n.cnt;
          n.vld = 1'b1;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1 <= mdl_reset();
      m3 <= mdl_reset();
    end else begin
      m1 <= mdl_next(m1, 1, load, enable, mode, int'(seed_in));
      m3 <= mdl_next(m3, 3, load, enable, mode, int'(seed_in));
    end
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_dut(input string tag, input logic [5:0] o,
                           input logic w, input logic l, input logic [5:0] p,
                           input logic v, input mdl_t e);
    chk({tag, "_out"},  int'(o), e.state);
    chk({tag, "_wrap"}, int'(w), int'(e.wrap));
    chk({tag, "_lock"}, int'(l), int'(e.lock));
    chk({tag, "_vld"},  int'(v), int'(e.vld));
    if (e.vld) chk({tag, "_period"}, int'(p), e.per);
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      check_dut("s1", out1, wrap1, lock1, per1, vld1, m1);
      check_dut("s3", out3, wrap3, lock3, per3, vld3, m3);
    end
  end

  // Apply one cycle of inputs (called at a negedge), return at the next one.
  task automatic drive(input bit ld, input bit en, input bit md,
                       input logic [5:0] seed);
    load = ld; enable = en; mode = md; seed_in = seed;
    @(negedge clk);
    if (verbose)
      $display("txn load=%0d en=%0d mode=%0d seed=%02h -> s1 out=%02h wrap=%0d lock=%0d per=%02h vld=%0d | s3 out=%02h wrap=%0d",
               ld, en, md, seed, out1, wrap1, lock1, per1, vld1, out3, wrap3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int fib_exp [6];
    int gal_exp [7];
    bit md;
    logic [5:0] sd;
    fib_exp = '{'h02, 'h04, 'h08, 'h10, 'h21, 'h03};
    gal_exp = '{'h02, 'h04, 'h08, 'h10, 'h20, 'h21, 'h23};

    // Reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    cmp_on = 1'b1;
    chk("rst_out",    int'(out1), 'h01);
    chk("rst_vld",    int'(vld1), 0);
    chk("rst_period", int'(per1), 0);
    chk("rst_wrap",   int'(wrap1), 0);
    chk("rst_lock",   int'(lock1), 0);

    // Fibonacci from reset; the 3-step instance sees the same enables
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 1'b0, 6'h00);
      chk("fib_seq", int'(out1), fib_exp[i]);
      if (i == 0) chk("fib3_seq", int'(out3), 'h08);
      if (i == 1) chk("fib3_seq", int'(out3), 'h03);
    end

    // Galois full period from seed 01
    drive(1'b1, 1'b0, 1'b1, 6'h01);
    chk("gal_load", int'(out1), 'h01);
    for (int i = 1; i <= 63; i++) begin
      drive(1'b0, 1'b1, 1'b1, 6'h00);
      if (i <= 7) chk("gal_seq", int'(out1), gal_exp[i-1]);
      if (i == 21) begin
        chk("gal3_wrap",   int'(wrap3), 1);
        chk("gal3_period", int'(per3), 21);
      end
    end
    chk("gal_wrap",   int'(wrap1), 1);
    chk("gal_out",    int'(out1), 'h01);
    chk("gal_period", int'(per1), 63);
    chk("gal_vld",    int'(vld1), 1);
    drive(1'b0, 1'b1, 1'b1, 6'h00);
    chk("gal_wrap_end", int'(wrap1), 0);
    chk("gal_period_hold", int'(per1), 63);

    // Asynchronous reset between edges
    drive(1'b0, 1'b1, 1'b1, 6'h00);
    load = 1'b0; enable = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out",  int'(out1), 'h01);
    chk("arst_vld",  int'(vld1), 0);
    chk("arst_wrap", int'(wrap1), 0);
    chk("arst_lock", int'(lock1), 0);
    chk("arst_out3", int'(out3), 'h01);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 6'h00);
    chk("arst_restart", int'(out1), 'h02);

    // Load priority and zero seed
    drive(1'b1, 1'b1, 1'b0, 6'h2A);
    chk("load_prio",  int'(out1), 'h2A);
    chk("load_prio3", int'(out3), 'h2A);
    drive(1'b1, 1'b0, 1'b0, 6'h00);
    chk("zero_out",  int'(out1), 'h01);
    chk("zero_lock", int'(lock1), 1);
    chk("zero_vld",  int'(vld1), 0);
    drive(1'b0, 1'b0, 1'b0, 6'h00);
    chk("zero_lock_end", int'(lock1), 0);

    // Mode switch then stall
    drive(1'b1, 1'b0, 1'b0, 6'h01);
    repeat (3) drive(1'b0, 1'b1, 1'b0, 6'h00);
    chk("msw_fib", int'(out1), 'h08);
    drive(1'b0, 1'b1, 1'b1, 6'h00);
    chk("msw_gal", int'(out1), 'h10);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b1, 6'h00);
      chk("stall_out", int'(out1), 'h10);
    end

    // Randomised traffic against the model
    verbose = 1'b0;
    md = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) md = ~md;
      sd = ($urandom_range(0, 5) == 0) ? 6'h00 : 6'($urandom_range(1, 63));
      drive(($urandom_range(0, 149) == 0), ($urandom_range(0, 9) < 8), md, sd);
    end

    cmp_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
